// File: rtl/rf_write_arbiter_pkg.sv
// Shared defaults and types for the register-file write-port arbiter.
// Widths follow the core's XLEN/XADDR; RF_STARVE_MAX is the codebase-wide aux starvation limit.
package rf_write_arbiter_pkg;

  localparam int RF_XLEN       = 32;
  localparam int RF_XADDR      = 5;
  localparam int RF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_PIPE = 2'd1,
    GRANT_AUX  = 2'd2
  } grant_e;

  function automatic int starveCntWidth(input int maxCount);
    return $clog2(maxCount + 1);
  endfunction

endpackage

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between the pipeline write-back stage
// and the multi-cycle aux unit, with bounded aux starvation and a registered write port.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int XLEN       = RF_XLEN,
  parameter int XADDR      = RF_XADDR,
  parameter int STARVE_MAX = RF_STARVE_MAX
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wb_write,
  input  logic [XADDR-1:0] i_wb_addr,
  input  logic [XLEN-1:0]  i_wb_data,
  input  logic             i_aux_valid,
  input  logic [XADDR-1:0] i_aux_addr,
  input  logic [XLEN-1:0]  i_aux_data,
  output logic             o_aux_ready,
  output logic             o_stall,
  output logic             or_rd_write,
  output logic [XADDR-1:0] or_rd_addr,
  output logic [XLEN-1:0]  or_rd_data
);

  localparam int            CW         = starveCntWidth(STARVE_MAX);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] r_starve_cnt;
  logic          w_p_req;
  logic          w_a_req;
  logic          w_a_nop;
  logic          w_aux_win;
  grant_e        w_grant;

  // Same-register conflicts go to aux: its instruction is older, so its write must land first.
  always_comb begin
    w_p_req   = i_wb_write && (i_wb_addr != '0);
    w_a_req   = i_aux_valid && (i_aux_addr != '0);
    w_a_nop   = i_aux_valid && (i_aux_addr == '0);
    w_aux_win = w_a_req && (!w_p_req || (r_starve_cnt == STARVE_LIM) || (i_aux_addr == i_wb_addr));
    w_grant   = GRANT_NONE;
    if (w_aux_win) begin
      w_grant = GRANT_AUX;
    end else if (w_p_req) begin
      w_grant = GRANT_PIPE;
    end
  end

  assign o_aux_ready = !i_rst && (w_aux_win || w_a_nop);
  assign o_stall     = !i_rst && w_p_req && w_aux_win;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
    end else if (w_a_req && !w_aux_win) begin
      if (r_starve_cnt != STARVE_LIM) begin
        r_starve_cnt <= r_starve_cnt + CW'(1);
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end

  // Address and data hold their last value on idle cycles; only the enable drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      or_rd_write <= 1'b0;
      or_rd_addr  <= '0;
      or_rd_data  <= '0;
    end else begin
      case (w_grant)
        GRANT_AUX: begin
          or_rd_write <= 1'b1;
          or_rd_addr  <= i_aux_addr;
          or_rd_data  <= i_aux_data;
        end
        GRANT_PIPE: begin
          or_rd_write <= 1'b1;
          or_rd_addr  <= i_wb_addr;
          or_rd_data  <= i_wb_data;
        end
        default: begin
          or_rd_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized scoreboard bench for rf_write_arbiter: expected writes are queued at issue
// time and a separate monitor pops them whenever the DUT asserts its write enable.
module tb_rf_write_arbiter;

  localparam int XLEN       = 32;
  localparam int XADDR      = 5;
  localparam int STARVE_MAX = 4;

  logic             clk;
  logic             rst;
  logic             wbWrite;
  logic [XADDR-1:0] wbAddr;
  logic [XLEN-1:0]  wbData;
  logic             auxValid;
  logic [XADDR-1:0] auxAddr;
  logic [XLEN-1:0]  auxData;
  logic             auxReady;
  logic             stall;
  logic             rdWrite;
  logic [XADDR-1:0] rdAddr;
  logic [XLEN-1:0]  rdData;

  int nVectors;
  int nMiscompares;

  // Reference model state: consecutive cycles the aux request has been refused.
  int lostCycles;
  logic [XADDR+XLEN-1:0] expWrites[$];

  logic expStall;
  logic expReady;

  rf_write_arbiter #(
    .XLEN(XLEN),
    .XADDR(XADDR),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_wb_write(wbWrite),
    .i_wb_addr(wbAddr),
    .i_wb_data(wbData),
    .i_aux_valid(auxValid),
    .i_aux_addr(auxAddr),
    .i_aux_data(auxData),
    .o_aux_ready(auxReady),
    .o_stall(stall),
    .or_rd_write(rdWrite),
    .or_rd_addr(rdAddr),
    .or_rd_data(rdData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every registered write the DUT presents must match the oldest expected write.
  always @(negedge clk) begin
    if (rdWrite === 1'b1) begin
      if (expWrites.size() == 0) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL unexpected_write: got addr %0d data %h expected no write at %0t",
                 rdAddr, rdData, $time);
      end else begin
        logic [XADDR+XLEN-1:0] exp;
        exp = expWrites.pop_front();
        checkOutput("rd_write", 64'({rdAddr, rdData}), 64'(exp));
      end
    end
  end

  // Drive one cycle of requests; the model decides the winner from the arbitration rules.
  task automatic applyStimulus(input logic w, input logic [XADDR-1:0] wa, input logic [XLEN-1:0] wd,
                               input logic av, input logic [XADDR-1:0] aa, input logic [XLEN-1:0] ad);
    bit pWants, aWants, aDrop, auxGets;
    rst      = 1'b0;
    wbWrite  = w;
    wbAddr   = wa;
    wbData   = wd;
    auxValid = av;
    auxAddr  = aa;
    auxData  = ad;
    pWants  = w && (wa != 0);
    aWants  = av && (aa != 0);
    aDrop   = av && (aa == 0);
    auxGets = aWants && (!pWants || lostCycles >= STARVE_MAX || aa == wa);
    expStall = pWants && auxGets;
    expReady = auxGets || aDrop;
    #1;
    checkOutput("o_stall", 64'(stall), 64'(expStall));
    checkOutput("o_aux_ready", 64'(auxReady), 64'(expReady));
    @(posedge clk);
    if (auxGets) expWrites.push_back({aa, ad});
    else if (pWants) expWrites.push_back({wa, wd});
    if (aWants && !auxGets) lostCycles = (lostCycles < STARVE_MAX) ? lostCycles + 1 : STARVE_MAX;
    else lostCycles = 0;
    @(negedge clk);
  endtask

  // One reset cycle with live requests: nothing may be accepted or written.
  task automatic resetCycle();
    rst      = 1'b1;
    wbWrite  = 1'b1;
    wbAddr   = 5'd6;
    wbData   = $urandom;
    auxValid = 1'b1;
    auxAddr  = 5'd6;
    auxData  = $urandom;
    #1;
    checkOutput("rst_o_stall", 64'(stall), 64'd0);
    checkOutput("rst_o_aux_ready", 64'(auxReady), 64'd0);
    @(posedge clk);
    lostCycles = 0;
    @(negedge clk);
    checkOutput("rst_or_rd", 64'({rdWrite, rdAddr, rdData}), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic             hW, hAv;
    logic [XADDR-1:0] hWa, hAa;
    logic [XLEN-1:0]  hWd, hAd;
    nVectors     = 0;
    nMiscompares = 0;
    lostCycles   = 0;
    rst = 1'b1; wbWrite = 0; wbAddr = 0; wbData = 0; auxValid = 0; auxAddr = 0; auxData = 0;
    @(negedge clk);
    resetCycle();
    resetCycle();

    applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    for (int i = 0; i < 6; i++) applyStimulus(1, 5'd3, 32'h3333_0000 + i, 1, 5'd7, 32'h7777_7777);
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    applyStimulus(1, 5'd9, 32'h1, 1, 5'd9, 32'h2);
    applyStimulus(1, 5'd9, 32'h1, 0, 5'd0, 32'h0);

    applyStimulus(1, 5'd4, 32'h4444_4444, 1, 5'd0, 32'hBAD0_BAD0);
    applyStimulus(1, 5'd0, 32'h0BAD_0BAD, 0, 5'd0, 32'h0);
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    for (int i = 0; i < 3; i++) applyStimulus(1, 5'd1, 32'h1111_0000 + i, 1, 5'd6, 32'h6666_6666);
    resetCycle();
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd6, 32'h6666_6666);
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // Random traffic with the real handshake: stalled wb and unaccepted aux re-present.
    hW = 0; hWa = 0; hWd = 0; hAv = 0; hAa = 0; hAd = 0;
    expStall = 0;
    expReady = 0;
    for (int i = 0; i < 400; i++) begin
      if (!expStall) begin
        hW  = ($urandom_range(0, 3) != 0);
        hWa = 5'($urandom_range(0, 4));
        hWd = $urandom;
      end
      if (!hAv || expReady) begin
        hAv = ($urandom_range(0, 1) != 0);
        hAa = 5'($urandom_range(0, 4));
        hAd = $urandom;
      end
      applyStimulus(hW, hWa, hWd, hAv, hAa, hAd);
    end
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    checkOutput("pending_writes", 64'(expWrites.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
